// File: rtl/axi_lite_master_if.sv
// AXI4-Lite signal bundle shared by the initiator and the slaves on the crossbar.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one load/store request into
// one AXI4-Lite read or write and returns a one-cycle response pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request, req_ready high
// RD_ADDR | arvalid high until the address handshake
// RD_DATA | rready high until read data arrives
// WR_REQ  | aw and w channels offered together, each drops after its handshake
// WR_RESP | bready high until the write response arrives
// RESP    | resp_valid pulse, then back to IDLE
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    axi_if.master               m
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;
    logic                aw_hs;
    logic                w_hs;
    logic                aw_fin;
    logic                w_fin;

    // Handshake detection; done flags fold in the handshake of the current cycle
    // so both channels completing together still advance in one step.
    always_comb begin
        aw_hs  = m.awvalid && m.awready;
        w_hs   = m.wvalid && m.wready;
        aw_fin = aw_done || aw_hs;
        w_fin  = w_done || w_hs;
    end

    // All handshake-side outputs decode from registered state only, so no
    // valid ever depends combinationally on a ready.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        m.arvalid  = (state == RD_ADDR);
        m.rready   = (state == RD_DATA);
        m.awvalid  = (state == WR_REQ) && !aw_done;
        m.wvalid   = (state == WR_REQ) && !w_done;
        m.bready   = (state == WR_RESP);
        m.araddr   = addr_q;
        m.awaddr   = addr_q;
        m.wdata    = wdata_q;
        m.wstrb    = wstrb_q;
    end

    // Transaction sequencing, request latching and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= req_we ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m.arvalid && m.arready) begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m.rvalid) begin
                        resp_rdata <= m.rdata;
                        resp_err   <= (m.rresp != 2'b00);
                        state      <= RESP;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m.bvalid) begin
                        resp_err <= (m.bresp != 2'b00);
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a latency-programmable AXI4-Lite slave (SRAM words,
// a UART data register and an erroring address), an expected-response queue fed
// by a behavioural memory model, table vectors, randomized traffic and corner cases.
module tb_axi_lite_master;

    localparam logic [31:0] UART_ADDR = 32'ha00003f8;
    localparam logic [31:0] ERR_ADDR  = 32'ha00003fc;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_lat;
        int          w_lat;
        int          b_lat;
        int          ar_lat;
        int          r_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          t_acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    axi_if #(.ADDR_W(32), .DATA_W(32)) m ();

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m          (m)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave configuration and per-transaction observation counters.
    int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit have_aw, have_w, b_pend, b_fire, r_pend, r_fire, aw_seen, w_seen;
    logic [31:0] aw_a, w_d, ar_a, b_addr, tmp, cur_addr;
    logic [3:0]  w_s;
    logic [31:0] smem [logic [31:0]];
    int aw_hs_n, w_hs_n, ar_hs_n, awv_cyc, wv_cyc, rr_cyc, bready_early, addr_bad, busy_ready;
    int uart_n = 0;
    logic [7:0] uart_ch = '0;

    task automatic clear_txn_counters();
        aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; awv_cyc = 0; wv_cyc = 0; rr_cyc = 0;
        bready_early = 0; addr_bad = 0; busy_ready = 0; aw_seen = 0; w_seen = 0;
    endtask

    // Slave: decides every ready/valid at the falling edge, so each handshake
    // it grants completes on the following rising edge.
    always @(negedge clk) begin
        if (reset) begin
            m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 0;
            m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            have_aw = 0; have_w = 0; b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
        end else begin
            if (m.bready && !(aw_seen && w_seen)) bready_early++;
            if (b_fire) begin m.bvalid = 0; b_fire = 0; end
            if (b_pend && !m.bvalid) begin
                if (b_wait >= b_lat) begin
                    m.bvalid = 1; m.bresp = (b_addr == ERR_ADDR) ? 2'b10 : 2'b00;
                    b_pend = 0; b_wait = 0;
                end else b_wait++;
            end
            if (m.bvalid && m.bready) b_fire = 1;

            if (m.rready) rr_cyc++;
            if (r_fire) begin m.rvalid = 0; r_fire = 0; end
            if (r_pend && !m.rvalid) begin
                if (r_wait >= r_lat) begin
                    m.rvalid = 1;
                    m.rresp  = (ar_a == ERR_ADDR) ? 2'b10 : 2'b00;
                    m.rdata  = (ar_a == ERR_ADDR || ar_a == UART_ADDR || !smem.exists(ar_a)) ? 32'h0 : smem[ar_a];
                    r_pend = 0; r_wait = 0;
                end else r_wait++;
            end
            if (m.rvalid && m.rready) r_fire = 1;

            m.awready = 0;
            if (m.awvalid) begin
                awv_cyc++;
                if (m.awaddr !== cur_addr) addr_bad++;
                if (aw_wait >= aw_lat) begin
                    m.awready = 1; aw_wait = 0; aw_a = m.awaddr; have_aw = 1; aw_seen = 1; aw_hs_n++;
                end else aw_wait++;
            end
            m.wready = 0;
            if (m.wvalid) begin
                wv_cyc++;
                if (w_wait >= w_lat) begin
                    m.wready = 1; w_wait = 0; w_d = m.wdata; w_s = m.wstrb; have_w = 1; w_seen = 1; w_hs_n++;
                end else w_wait++;
            end
            m.arready = 0;
            if (m.arvalid) begin
                if (m.araddr !== cur_addr) addr_bad++;
                if (ar_wait >= ar_lat) begin
                    m.arready = 1; ar_wait = 0; ar_a = m.araddr; r_pend = 1; ar_hs_n++;
                end else ar_wait++;
            end

            if (have_aw && have_w) begin
                have_aw = 0; have_w = 0; b_pend = 1; b_addr = aw_a;
                if (aw_a == UART_ADDR) begin
                    uart_n++; uart_ch = w_d[7:0];
                end else if (aw_a != ERR_ADDR) begin
                    tmp = smem.exists(aw_a) ? smem[aw_a] : 32'h0;
                    for (int b = 0; b < 4; b++) if (w_s[b]) tmp[8*b +: 8] = w_d[8*b +: 8];
                    smem[aw_a] = tmp;
                end
            end
        end
    end

    // Response monitor: every pulse must match the oldest outstanding expectation.
    exp_t exp_q[$];
    int   pulse_n = 0;

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            pulse_n++;
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL spurious_resp: got a resp_valid pulse, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                chk("latency", cyc - e.t_acc, e.lat);
            end
        end
    end

    // Behavioural model: memory image plus the last response data the requester saw.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] model_last = '0;

    task automatic model_predict(input bit we, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output logic [31:0] rd, output bit err);
        logic [31:0] mask, old;
        err = (a == ERR_ADDR);
        if (we) begin
            rd = model_last;
            if (!err && a != UART_ADDR) begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                old  = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
                ref_mem[a] = (old & ~mask) | (d & mask);
            end
        end else begin
            rd = (err || a == UART_ADDR || !ref_mem.exists(a)) ? 32'h0 : ref_mem[a];
        end
    endtask

    // Present a request and return at the falling edge after it was accepted,
    // leaving req_valid high so a caller can chain the next request.
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd, input bit exp_err, output int t_acc);
        exp_t e;
        bit   ok = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        t_acc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (req_ready) begin
                ok = 1;
                chk("no_overlap", exp_q.size(), 0);
                e.rdata = exp_rd; e.err = exp_err; e.t_acc = cyc;
                e.lat   = we ? 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat : 3 + ar_lat + r_lat;
                exp_q.push_back(e);
                model_last = exp_rd;
                t_acc = cyc;
                cur_addr = a;
                clear_txn_counters();
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected acceptance within 100 cycles");
        end
    endtask

    task automatic wait_resp();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0) done = 1;
            else begin
                if (req_ready) busy_ready++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL resp_timeout: %0d responses missing, expected all within 200 cycles", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run1(input vec_t v);
        int t;
        aw_lat = v.aw_lat; w_lat = v.w_lat; b_lat = v.b_lat; ar_lat = v.ar_lat; r_lat = v.r_lat;
        issue(v.we, v.addr, v.wdata, v.wstrb, v.exp_rdata, v.exp_err, t);
        req_valid = 0;
        wait_resp();
        @(negedge clk);
        chk("aw_handshakes", aw_hs_n, {31'b0, v.we});
        chk("w_handshakes", w_hs_n, {31'b0, v.we});
        chk("ar_handshakes", ar_hs_n, {31'b0, !v.we});
        if (v.we) begin
            chk("awvalid_cycles", awv_cyc, v.aw_lat + 1);
            chk("wvalid_cycles", wv_cyc, v.w_lat + 1);
        end else begin
            chk("rready_cycles", rr_cyc, v.r_lat + 1);
        end
        chk("bready_early", bready_early, 0);
        chk("addr_stable", addr_bad, 0);
        chk("req_ready_busy", busy_ready, 0);
    endtask

    vec_t tbl[10];

    initial begin
        int t0, t1, t2, p0;
        vec_t v;

        //      we  addr        wdata          strb  aw w  b  ar r  exp_rdata      err
        tbl[0] = '{1, UART_ADDR, 32'h00000041, 4'hF, 0, 0, 0, 0, 0, 32'h00000000, 0};
        tbl[1] = '{0, UART_ADDR, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h00000000, 0};
        tbl[2] = '{1, ERR_ADDR,  32'h00000055, 4'hF, 0, 0, 0, 0, 0, 32'h00000000, 1};
        tbl[3] = '{1, 32'h1000,  32'h12345678, 4'hF, 3, 0, 0, 0, 0, 32'h00000000, 0};
        tbl[4] = '{0, 32'h1000,  32'h0,        4'h0, 0, 0, 0, 0, 5, 32'h12345678, 0};
        tbl[5] = '{1, 32'h1000,  32'hAABBCCDD, 4'h5, 0, 2, 2, 0, 0, 32'h12345678, 0};
        tbl[6] = '{0, 32'h1000,  32'h0,        4'h0, 0, 0, 0, 2, 1, 32'h12BB56DD, 0};
        tbl[7] = '{0, ERR_ADDR,  32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h00000000, 1};
        tbl[8] = '{1, 32'h1004,  32'hCAFEF00D, 4'hC, 1, 1, 1, 0, 0, 32'h00000000, 0};
        tbl[9] = '{0, 32'h1004,  32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hCAFE0000, 0};

        clear_txn_counters();
        cur_addr = '0;
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_valids", {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready, resp_valid}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", {31'b0, resp_err}, 0);
        chk("rst_araddr", m.araddr, 0);
        reset = 0;
        @(negedge clk);

        foreach (tbl[i]) run1(tbl[i]);
        chk("uart_chars", uart_n, 1);
        chk("uart_char", {24'b0, uart_ch}, 32'h41);

        // Slow read data: rready held, requester blocked until after the pulse.
        smem[32'h3000] = 32'hDEADBEEF;
        v = '{0, 32'h3000, 32'h0, 4'h0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0};
        run1(v);

        // Reset while waiting in RD_DATA: no pulse, everything quiet one cycle later.
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 20;
        issue(0, 32'h1000, 32'h0, 4'h0, 32'h12BB56DD, 0, t0);
        req_valid = 0;
        for (int i = 0; i < 20 && !m.rready; i++) @(negedge clk);
        chk("in_rd_data", {31'b0, m.rready}, 1);
        p0 = pulse_n;
        reset = 1;
        @(negedge clk);
        chk("midrst_valids", {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready, resp_valid}, 0);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        chk("midrst_resp_rdata", resp_rdata, 0);
        exp_q.delete();
        model_last = 0;
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", pulse_n, p0);
        v = '{0, 32'h1000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h12BB56DD, 0};
        run1(v);

        // Back-to-back write/read/write with req_valid held high.
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        p0 = pulse_n;
        issue(1, 32'h1008, 32'h01020304, 4'hF, 32'h12BB56DD, 0, t0);
        issue(0, 32'h1008, 32'h0, 4'h0, 32'h01020304, 0, t1);
        issue(1, ERR_ADDR, 32'h77, 4'hF, 32'h01020304, 1, t2);
        req_valid = 0;
        wait_resp();
        @(negedge clk);
        chk("b2b_spacing1", t1 - t0, 4);
        chk("b2b_spacing2", t2 - t1, 4);
        chk("b2b_pulses", pulse_n - p0, 3);

        // Keep the behavioural model in step with what the SRAM already holds.
        ref_mem[32'h1000] = 32'h12BB56DD;
        ref_mem[32'h1004] = 32'hCAFE0000;
        ref_mem[32'h1008] = 32'h01020304;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, rd;
            bit er;
            v.we     = $urandom_range(0, 1);
            a        = ($urandom_range(0, 7) == 0) ? ERR_ADDR : 32'h1000 + 4 * $urandom_range(0, 5);
            v.addr   = a;
            v.wdata  = $urandom;
            v.wstrb  = 4'($urandom_range(0, 15));
            v.aw_lat = $urandom_range(0, 3);
            v.w_lat  = $urandom_range(0, 3);
            v.b_lat  = $urandom_range(0, 3);
            v.ar_lat = $urandom_range(0, 3);
            v.r_lat  = $urandom_range(0, 3);
            model_predict(v.we, v.addr, v.wdata, v.wstrb, rd, er);
            v.exp_rdata = rd;
            v.exp_err   = er;
            run1(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
